// File: rtl/shader_pixel_feeder.sv
// Raster-order pixel request scheduler for shader_pipeline with a colour FIFO
// tagged by start-of-frame / start-of-line, drained through a ready/valid port.
module shader_pixel_feeder #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       frame_start,
    output logic [9:0]                 pixel_x,
    output logic [9:0]                 pixel_y,
    output logic                       pixel_valid,
    input  logic                       color_valid,
    input  logic [7:0]                 red_in,
    input  logic [7:0]                 green_in,
    input  logic [7:0]                 blue_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [23:0]                out_rgb,
    output logic                       out_sof,
    output logic                       out_sol,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
    output logic                       frame_done,
    output logic [15:0]                timeout_count
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = FIFO_ADDR_WIDTH + 1;

    state_t                     r_state;
    logic [9:0]                 r_x;
    logic [9:0]                 r_y;
    logic                       r_pixel_valid;
    logic                       r_pending;
    logic                       r_frame_done;
    logic [CW-1:0]              r_wait_cnt;
    logic [15:0]                r_timeout_count;
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]              r_level;
    logic [25:0]                r_mem [FIFO_DEPTH];

    logic          w_expired;
    logic          w_done;
    logic          w_timeout;
    logic          w_pop;
    logic          w_restart;
    logic          w_last_x;
    logic          w_last_y;
    logic          w_room_now;
    logic          w_room_next;
    logic [LW-1:0] w_level_next;
    logic [25:0]   w_entry;
    logic [25:0]   w_head;

    assign w_expired    = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_done       = (r_state == S_WAIT) && (color_valid || w_expired);
    assign w_timeout    = (r_state == S_WAIT) && w_expired && !color_valid;
    assign w_pop        = (r_level != '0) && out_ready;
    assign w_restart    = r_pending || frame_start;
    assign w_last_x     = (r_x == 10'(H_ACTIVE - 1));
    assign w_last_y     = (r_y == 10'(V_ACTIVE - 1));
    assign w_level_next = r_level + LW'(w_done) - LW'(w_pop);
    assign w_room_now   = (r_level != LW'(FIFO_DEPTH));
    assign w_room_next  = (w_level_next != LW'(FIFO_DEPTH));
    // A timed-out pixel is substituted with black; tags always use the in-flight coordinates.
    assign w_entry      = {(color_valid ? {red_in, green_in, blue_in} : 24'h000000),
                           (r_x == '0) && (r_y == '0), (r_x == '0)};

    always_ff @(posedge clk) begin
        if (w_done) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_pixel_valid   <= 1'b0;
            r_pending       <= 1'b0;
            r_frame_done    <= 1'b0;
            r_wait_cnt      <= '0;
            r_timeout_count <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_level       <= w_level_next;
            if (w_done) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_ADDR_WIDTH'(1);
            if (frame_start) r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_restart) begin
                        r_x       <= '0;
                        r_y       <= '0;
                        r_pending <= 1'b0;
                    end
                    if (enable && w_room_now) begin
                        r_state       <= S_ISSUE;
                        r_pixel_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (w_done) begin
                        if (w_timeout && (r_timeout_count != 16'hFFFF))
                            r_timeout_count <= r_timeout_count + 16'd1;
                        r_frame_done <= w_last_x && w_last_y;
                        // A pending restart overrides the raster advance.
                        if (w_restart) begin
                            r_x       <= '0;
                            r_y       <= '0;
                            r_pending <= 1'b0;
                        end else if (w_last_x) begin
                            r_x <= '0;
                            r_y <= w_last_y ? 10'd0 : r_y + 10'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                        if (enable && w_room_next) begin
                            r_state       <= S_ISSUE;
                            r_pixel_valid <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign out_valid     = (r_level != '0);
    assign out_rgb       = out_valid ? w_head[25:2] : 24'h000000;
    assign out_sof       = out_valid && w_head[1];
    assign out_sol       = out_valid && w_head[0];
    assign fifo_level    = r_level;
    assign pixel_x       = r_x;
    assign pixel_y       = r_y;
    assign pixel_valid   = r_pixel_valid;
    assign frame_done    = r_frame_done;
    assign timeout_count = r_timeout_count;
endmodule

// File: tb/tb_shader_pixel_feeder.sv
// Randomised bench for shader_pixel_feeder: a shader responder plus a transaction-level
// raster/FIFO reference model, with directed phases for stall, timeout, restart and reset.
module tb_shader_pixel_feeder;
    localparam int H = 20, V = 3, DEPTH = 16, AW = 4, TO = 64;

    logic        clk = 1'b0, rst = 1'b0;
    logic        enable = 1'b0, frame_start = 1'b0, color_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  red_in = '0, green_in = '0, blue_in = '0;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid, out_valid, out_sof, out_sol, frame_done;
    logic [23:0] out_rgb;
    logic [AW:0] fifo_level;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    shader_pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH),
                          .FIFO_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .color_valid(color_valid), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
        .out_sof(out_sof), .out_sol(out_sol), .fifo_level(fifo_level),
        .frame_done(frame_done), .timeout_count(timeout_count)
    );

    typedef struct packed {logic [23:0] rgb; logic sof; logic sol;} ent_t;
    ent_t q[$];

    int n_checks = 0, n_errors = 0;
    // reference model: next raster coordinate, the one outstanding request, counters
    bit          outst = 0, restart = 0, exp_fd = 0;
    int          wait_cnt = 0, resp_cnt = 0, exp_x = 0, exp_y = 0, ox = 0, oy = 0, tc = 0;
    logic [23:0] req_rgb = '0;
    // stimulus controls
    bit en_drv = 0, en_rand = 0, ready_fix = 0, ready_rand = 0, fs_req = 0, force_cv = 0;
    bit stray = 0, rand_mode = 0, p1_first = 0;
    int fixed_resp = 3;
    int cyc = 0, pv_count = 0, pv_cyc_prev = 0, pv_cyc_last = 0, last_pv_x = 0, last_pv_y = 0;
    int fd_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] shade(input int x, input int y);
        return {8'(x), 8'(y), 8'h5A};
    endfunction

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0; color_valid = 1'b0; out_ready = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0;
        #1;
        check_val("rst_pixel_x", pixel_x, 0);
        check_val("rst_pixel_y", pixel_y, 0);
        check_val("rst_pixel_valid", pixel_valid, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_rgb", out_rgb, 0);
        check_val("rst_out_sof", out_sof, 0);
        check_val("rst_out_sol", out_sol, 0);
        check_val("rst_fifo_level", fifo_level, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_timeout_count", timeout_count, 0);
        q.delete(); outst = 0; restart = 0; exp_fd = 0; exp_x = 0; exp_y = 0; tc = 0; fd_count = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare all outputs.
    task automatic cycle();
        bit          cv, completing, timed_out, pop, en, rdy, fs, exp_pv;
        logic [23:0] rgb;
        int          lvl;
        ent_t        e;
        cv = 0; completing = 0; timed_out = 0; rgb = '0;
        if (outst && wait_cnt >= 0) begin
            if (wait_cnt == resp_cnt) begin cv = 1; rgb = req_rgb; end
            completing = cv || (wait_cnt == TO - 1);
            timed_out  = completing && !cv;
        end else if (stray && $urandom_range(0, 7) == 0) begin
            cv = 1; rgb = 24'($urandom);
        end
        if (force_cv) begin cv = 1; rgb = 24'hABCDEF; force_cv = 0; end
        fs = fs_req; fs_req = 0;
        if (fs) begin
            if (!outst) begin exp_x = 0; exp_y = 0; end
            else restart = 1;
        end
        en  = en_rand ? ($urandom_range(0, 7) != 0) : en_drv;
        rdy = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
        lvl = q.size();
        pop = rdy && (lvl > 0);
        exp_pv = outst ? (completing && en && (lvl + 1 - int'(pop)) < DEPTH) : (en && lvl < DEPTH);
        enable = en; out_ready = rdy; frame_start = fs; color_valid = cv;
        {red_in, green_in, blue_in} = rgb;

        @(posedge clk); #1; cyc++;

        if (pop) void'(q.pop_front());
        exp_fd = 0;
        if (completing) begin
            e.rgb = cv ? rgb : 24'h0; e.sof = (ox == 0 && oy == 0); e.sol = (ox == 0);
            q.push_back(e);
            if (timed_out && tc < 65535) tc++;
            exp_fd = (ox == H - 1 && oy == V - 1);
            if (restart) begin
                exp_x = 0; exp_y = 0; restart = 0;
            end else begin
                exp_x = (ox + 1) % H;
                exp_y = (ox == H - 1) ? (oy + 1) % V : oy;
            end
            outst = 0;
        end else if (outst) begin
            wait_cnt++;
        end

        check_val("pixel_valid", pixel_valid, exp_pv);
        if (pixel_valid) begin
            check_val("req_x", pixel_x, exp_x);
            check_val("req_y", pixel_y, exp_y);
            pv_count++; pv_cyc_prev = pv_cyc_last; pv_cyc_last = cyc;
            last_pv_x = pixel_x; last_pv_y = pixel_y;
            outst = 1; wait_cnt = -1; ox = exp_x; oy = exp_y;
            if (rand_mode) begin
                resp_cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 80) : $urandom_range(0, 12);
                req_rgb  = 24'($urandom);
            end else begin
                resp_cnt = fixed_resp;
                req_rgb  = shade(ox, oy);
            end
        end else if (outst) begin
            check_val("hold_x", pixel_x, ox);
            check_val("hold_y", pixel_y, oy);
        end
        check_val("fifo_level", fifo_level, q.size());
        check_val("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_val("out_rgb", out_rgb, q[0].rgb);
            check_val("out_sof", out_sof, q[0].sof);
            check_val("out_sol", out_sol, q[0].sol);
        end
        check_val("frame_done", frame_done, exp_fd);
        if (frame_done) fd_count++;
        check_val("timeout_count", timeout_count, tc);
        if (p1_first && out_valid) begin
            check_val("first_rgb", out_rgb, 24'h00005A);
            check_val("first_sof", out_sof, 1);
            check_val("first_sol", out_sol, 1);
            p1_first = 0;
        end
    endtask

    initial begin
        int g, pv_before;
        #2;
        // basic streaming with a 4-cycle shader
        do_reset(); en_drv = 1; ready_fix = 1; p1_first = 1; fixed_resp = 3;
        repeat (40) cycle();
        check_val("pv_period", pv_cyc_last - pv_cyc_prev, 5);
        $display("phase stream: %0d requests by cycle %0d", pv_count, cyc);

        // consumer stall fills the FIFO, then resumes
        do_reset(); ready_fix = 0;
        repeat (120) cycle();
        check_val("stall_level", fifo_level, 16);
        check_val("stall_x", pixel_x, 16);
        check_val("stall_pv", pixel_valid, 0);
        ready_fix = 1;
        repeat (60) cycle();
        $display("phase stall: resumed at cycle %0d", cyc);

        // shader never answers, then answers on the final wait cycle
        do_reset(); fixed_resp = 1000;
        repeat (66) cycle();
        check_val("to_count", timeout_count, 1);
        check_val("to_rgb", out_rgb, 0);
        do_reset(); fixed_resp = TO - 1;
        repeat (66) cycle();
        check_val("late_count", timeout_count, 0);
        check_val("late_rgb", out_rgb, 24'h00005A);
        $display("phase timeout: done at cycle %0d", cyc);

        // one full frame
        do_reset(); fixed_resp = 3;
        repeat (H * V * 5 + 10) cycle();
        check_val("frame_done_count", fd_count, 1);
        $display("phase frame: %0d frame_done pulses", fd_count);

        // frame_start while waiting on (2,1), then coincident with last-pixel completion
        do_reset();
        g = 0;
        while (!(outst && ox == 2 && oy == 1 && wait_cnt == 0) && g < 500) begin cycle(); g++; end
        check_val("reach_2_1", g < 500, 1);
        fs_req = 1; pv_before = pv_count; g = 0;
        while (pv_count == pv_before && g < 20) begin cycle(); g++; end
        check_val("restart_x", last_pv_x, 0);
        check_val("restart_y", last_pv_y, 0);
        g = 0;
        while (!(outst && ox == H - 1 && oy == V - 1 && wait_cnt == 3) && g < 400) begin cycle(); g++; end
        check_val("reach_last", g < 400, 1);
        fs_req = 1;
        cycle();
        check_val("fs_last_fd", frame_done, 1);
        check_val("fs_last_pv", pixel_valid, 1);
        check_val("fs_last_x", pixel_x, 0);
        check_val("fs_last_y", pixel_y, 0);
        repeat (10) cycle();
        $display("phase restart: done at cycle %0d", cyc);

        // reset mid-WAIT with queued entries, then a stale colour strobe
        do_reset(); ready_fix = 0;
        g = 0;
        while (!(q.size() == 5 && outst && wait_cnt >= 0) && g < 100) begin cycle(); g++; end
        check_val("reach_5_queued", g < 100, 1);
        do_reset();
        force_cv = 1; ready_fix = 1;
        cycle();
        check_val("post_rst_level", fifo_level, 0);
        repeat (20) cycle();
        $display("phase reset: done at cycle %0d", cyc);

        // randomised traffic
        rand_mode = 1; stray = 1; ready_rand = 1; en_rand = 1;
        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) fs_req = 1;
            cycle();
        end
        $display("phase random: %0d requests, %0d timeouts by cycle %0d", pv_count, tc, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/shader_pixel_feeder.md
# shader_pixel_feeder

Raster-order pixel request scheduler and colour FIFO sitting directly upstream of `shader_pipeline`. It issues one pixel coordinate at a time on the shader's `pixel_x`/`pixel_y`/`pixel_valid` inputs and holds the coordinate stable until `color_valid` returns. It captures `red_out`/`green_out`/`blue_out` into a small FIFO tagged with start-of-frame and start-of-line markers. A ready/valid port drains the FIFO toward the HDMI line/frame buffer.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `FIFO_DEPTH`, 16: colour FIFO entries (power of two).
- `FIFO_ADDR_WIDTH`, 4: log2(`FIFO_DEPTH`).
- `TIMEOUT_CYCLES`, 64: maximum wait for `color_valid` before a fallback pixel is substituted.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allow new pixel requests.
- `frame_start`  in  1  pulse; restart the raster at (0,0).
- `pixel_x`  out  10  current request x; to shader `pixel_x`.
- `pixel_y`  out  10  current request y; to shader `pixel_y`.
- `pixel_valid`  out  1  one-cycle request pulse; to shader `pixel_valid`.
- `color_valid`  in  1  shader result strobe.
- `red_in`, `green_in`, `blue_in`  in  8 each  shader colour, sampled when `color_valid`=1.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_rgb`  out  24  {R,G,B} of the head.
- `out_sof`  out  1  head is pixel (0,0).
- `out_sol`  out  1  head is x=0.
- `fifo_level`  out  FIFO_ADDR_WIDTH+1  occupied entries.
- `frame_done`  out  1  one-cycle pulse when pixel (H_ACTIVE-1, V_ACTIVE-1) completes.
- `timeout_count`  out  16  saturating count of substituted pixels.

## Operation
- Reset values: all outputs 0, FSM in IDLE, coordinates (0,0), FIFO empty, pending-restart flag clear.
- FSM has three states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when `enable`=1 and `fifo_level` < `FIFO_DEPTH`; otherwise the FSM stays in IDLE.
- ISSUE: `pixel_valid`=1 for exactly this cycle; next state is WAIT. At most one request is outstanding, so the FIFO has space for the result.
- WAIT: the wait counter runs from 0 and `pixel_x`/`pixel_y` are held constant, because the shader reads them combinationally until it outputs the colour.
  - Completion on `color_valid`=1: push {rgb, sof, sol}.
  - Completion when the wait counter reaches `TIMEOUT_CYCLES`-1 with no `color_valid`: push rgb=24'h000000 and increment `timeout_count`, saturating at 16'hFFFF.
  - `color_valid` on the timeout cycle itself: the real colour wins and `timeout_count` is unchanged.
- After completion:
  - Advance coordinates: x+1; at x=H_ACTIVE-1, x→0 and y+1; at the last pixel, both →0 and `frame_done` pulses.
  - Next state is ISSUE if `enable`=1 and post-push level < `FIFO_DEPTH`, else IDLE.
- `color_valid` outside WAIT is ignored and nothing is pushed.
- `frame_start`:
  - Sets the pending flag in any state.
  - The flag is applied at the next pixel boundary: on a completion cycle, or on any cycle while in IDLE. Applying it forces coordinates to (0,0), overriding the advance, and clears the flag.
  - An in-flight request always completes with its original coordinates.
  - The FIFO is never flushed.
- `frame_start` on the same cycle as last-pixel completion: coordinates →(0,0) and `frame_done` still pulses.
- Deasserting `enable` never aborts WAIT; the FSM parks in IDLE after the completion.
- FIFO behaviour:
  - Pop occurs when `out_valid` && `out_ready`.
  - Simultaneous push and pop leaves the level unchanged.
  - `out_valid` = (level ≠ 0).
  - `out_rgb`/`out_sof`/`out_sol` show the head entry and hold while `out_ready`=0.
- Reset asserted mid-operation clears the FSM, coordinates and FIFO immediately. A stale `color_valid` after reset is ignored because the FSM is not in WAIT.

## Timing
- `pixel_valid` rises one cycle after IDLE→ISSUE is decided.
- `color_valid` sampled at edge N gives:
  - `out_valid`=1 and `fifo_level` updated after edge N, when the FIFO was empty;
  - the next `pixel_valid` one cycle after edge N.
- Per-pixel period is (shader latency from `pixel_valid` to `color_valid`) + 1 cycle.
- `frame_done` is registered and coincides with the cycle in which the final pixel's entry becomes visible in the FIFO.

## Test plan
- Reset, `enable`=1, shader model returning `color_valid` 4 cycles after each `pixel_valid` with rgb=x[7:0],y[7:0],0x5A, `out_ready`=1:
  - first `out_rgb`=0x00005A with `out_sof`=1 and `out_sol`=1;
  - pixel_valid period is 5 cycles.
- `out_ready`=0 for 20 pixels: `fifo_level` stops at 16, `pixel_valid` stays 0, coordinates hold at x=16; raising `out_ready` resumes requests at x=16 with no loss or duplicate.
- Shader never responds: a pixel is pushed 64 cycles after `pixel_valid` with rgb=0 and `timeout_count`=1. `color_valid` arriving on cycle 63 pushes the real colour and `timeout_count` stays 0.
- H_ACTIVE=4, V_ACTIVE=3 full frame: 12 entries; `out_sol` on x=0 entries; `frame_done` pulses once; the thirteenth request is (0,0) with `out_sof`=1.
- `frame_start` while WAIT at (2,1): the current pixel completes tagged (2,1) and the next request is (0,0); `frame_start` coincident with the last-pixel completion gives a `frame_done` pulse and next request (0,0).
- Assert `rst` during WAIT with 5 entries queued: all outputs 0 at once; a `color_valid` one cycle after release produces no push.
